audio_voice_scheduler: RTL

AUDIO_VOICE_SCHEDULER -- requirements
Module: audio_voice_scheduler

---
 rtl/audio_pkg.sv | 11 +
 rtl/audio_voice_amp.sv | 12 +
 rtl/audio_voice_scheduler.sv | 86 ++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sizes, config register codes and scheduler FSM states
package audio_pkg;
  localparam int NUM_VOICES = 4;
  localparam int PHASE_W = 16;
  localparam int SAMPLE_W = 10;
  localparam logic [1:0] REG_INC_LO = 2'd0;
  localparam logic [1:0] REG_INC_HI = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_PH_CLR = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_PROC, ST_OUT} state_t;
endpackage

// File: rtl/audio_voice_amp.sv
// audio_voice_amp: maps a voice's new phase, waveform and volume to its 8-bit mix contribution
// Ports: i_phase_hi = phase_new[15:8], i_wave (0 saw, 1 square), i_vol, o_contrib = (amp*vol)>>4
module audio_voice_amp (
  input  logic [7:0] i_phase_hi,
  input  logic       i_wave,
  input  logic [3:0] i_vol,
  output logic [7:0] o_contrib
);
  logic [7:0] w_amp;
  assign w_amp = i_wave ? {8{i_phase_hi[7]}} : i_phase_hi;
  assign o_contrib = 8'(({4'b0, w_amp} * {8'b0, i_vol}) >> 4);
endmodule

// File: rtl/audio_voice_scheduler.sv
// audio_voice_scheduler: time-multiplexed phase-accumulator voices mixed into one sample per tick
// Ports: sample_tick starts a frame; cfg_we/cfg_addr{voice,reg}/cfg_data write voice registers;
// sample_out/sample_valid deliver the mix; busy marks a frame in flight; overrun flags a dropped tick
module audio_voice_scheduler #(
  parameter int NUM_VOICES = audio_pkg::NUM_VOICES,
  parameter int PHASE_W = audio_pkg::PHASE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          cfg_we,
  input  logic [3:0]                    cfg_addr,
  input  logic [7:0]                    cfg_data,
  output logic [audio_pkg::SAMPLE_W-1:0] sample_out,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun
);
  import audio_pkg::*;
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  state_t r_state;
  logic [VW-1:0] r_vidx;
  logic [SAMPLE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_inc [NUM_VOICES];
  logic [PHASE_W-1:0] r_phase [NUM_VOICES];
  logic [5:0] r_ctrl [NUM_VOICES];
  logic [PHASE_W-1:0] w_phase_new;
  logic [5:0] w_ctrl;
  logic [7:0] w_contrib;
  logic [1:0] w_cv, w_cr;
  assign w_ctrl = r_ctrl[r_vidx];
  assign w_phase_new = r_phase[r_vidx] + r_inc[r_vidx];
  assign w_cv = cfg_addr[3:2];
  assign w_cr = cfg_addr[1:0];
  assign busy = r_state != ST_IDLE;
  audio_voice_amp u_amp (
    .i_phase_hi(w_phase_new[PHASE_W-1 -: 8]),
    .i_wave    (w_ctrl[4]),
    .i_vol     (w_ctrl[3:0]),
    .o_contrib (w_contrib)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vidx <= '0;
      r_acc <= '0;
      sample_out <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_inc[i] <= '0;
        r_phase[i] <= '0;
        r_ctrl[i] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      overrun <= sample_tick && r_state != ST_IDLE;
      case (r_state)
        ST_IDLE: if (sample_tick) begin
          r_state <= ST_PROC;
          r_vidx <= '0;
          r_acc <= '0;
        end
        ST_PROC: begin
          if (w_ctrl[5]) r_phase[r_vidx] <= w_phase_new;
          r_acc <= r_acc + (w_ctrl[5] ? SAMPLE_W'(w_contrib) : '0);
          r_vidx <= r_vidx + 1'b1;
          if (r_vidx == VW'(NUM_VOICES - 1)) r_state <= ST_OUT;
        end
        default: begin
          sample_out <= r_acc;
          sample_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
      // config writes land after the writeback so a phase clear overrides it
      for (int i = 0; i < NUM_VOICES; i++)
        if (cfg_we && w_cv == 2'(i)) begin
          if (w_cr == REG_INC_LO) r_inc[i][7:0] <= cfg_data;
          if (w_cr == REG_INC_HI) r_inc[i][15:8] <= cfg_data;
          if (w_cr == REG_CTRL) r_ctrl[i] <= cfg_data[5:0];
          if (w_cr == REG_PH_CLR) r_phase[i] <= '0;
        end
    end
  end
endmodule
